// File: rtl/nibbler_sequencer_if.sv
// Bus between the Nibbler fetch/sequencing stage and its surroundings
// (program ROM, control decoder, ALU flags).
//   master : drives run, rom_data, ctrl, alu_carry, alu_zero; observes sequencer state
//   slave  : the sequencer; drives pc, phase, instr, imm, addr, C, Zeta, instr_count
interface nibbler_sequencer_if #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 run;
    logic [7:0]           rom_data;
    logic [12:0]          ctrl;
    logic                 alu_carry;
    logic                 alu_zero;
    logic [PC_WIDTH-1:0]  pc;
    logic                 phase;
    logic [3:0]           instr;
    logic [3:0]           imm;
    logic [11:0]          addr;
    logic                 C;
    logic                 Zeta;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        output run, rom_data, ctrl, alu_carry, alu_zero,
        input  pc, phase, instr, imm, addr, C, Zeta, instr_count
    );

    modport slave (
        input  run, rom_data, ctrl, alu_carry, alu_zero,
        output pc, phase, instr, imm, addr, C, Zeta, instr_count
    );
endinterface

// File: rtl/nibbler_sequencer.sv
// Fetch/sequencing stage of the 4-bit Nibbler core: program counter,
// fetch/execute phase flop, 8-bit instruction register, C/Z flags and a
// retired-instruction counter.
//   clock  : rising-edge system clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of nibbler_sequencer_if
//            in  run, rom_data[7:0], ctrl[12:0], alu_carry, alu_zero
//            out pc, phase, instr, imm, addr[11:0] (combinational), C, Zeta, instr_count
module nibbler_sequencer #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    nibbler_sequencer_if.slave bus
);

    localparam int unsigned IR_W     = 8;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned CTRL_INC = 12;
    localparam int unsigned CTRL_LD  = 11;
    localparam int unsigned CTRL_FLG = 9;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

    phase_e               r_phase;
    phase_e               w_phase_nxt;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  w_pc_nxt;
    logic [IR_W-1:0]      r_ir;
    logic [IR_W-1:0]      w_ir_nxt;
    logic                 r_c;
    logic                 w_c_nxt;
    logic                 r_z;
    logic                 w_z_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_unused_ctrl;

    // Datapath-only control bits pass by this block untouched.
    assign w_unused_ctrl = ^{bus.ctrl[10], bus.ctrl[8:0]};

    // Jump/RAM address: low nibble of the latched opcode byte over the following ROM byte.
    assign w_addr = {r_ir[NIB_W-1:0], bus.rom_data};

    // Phase state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_phase <= PH_FETCH;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Phase toggles on every enabled edge.
    always_comb begin
        w_phase_nxt = r_phase;
        if (bus.run) begin
            w_phase_nxt = (r_phase == PH_FETCH) ? PH_EXEC : PH_FETCH;
        end
    end

    // Per-phase datapath next values; everything holds unless run is high.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_ir_nxt  = r_ir;
        w_c_nxt   = r_c;
        w_z_nxt   = r_z;
        w_cnt_nxt = r_cnt;
        if (bus.run) begin
            if (r_phase == PH_FETCH) begin
                w_ir_nxt = bus.rom_data;
                if (bus.ctrl[CTRL_INC]) begin
                    w_pc_nxt = r_pc + PC_WIDTH'(1);
                end
            end else begin
                // loadPC has priority over incPC.
                if (bus.ctrl[CTRL_LD]) begin
                    w_pc_nxt = PC_WIDTH'(w_addr);
                end else if (bus.ctrl[CTRL_INC]) begin
                    w_pc_nxt = r_pc + PC_WIDTH'(1);
                end
                if (bus.ctrl[CTRL_FLG]) begin
                    w_c_nxt = bus.alu_carry;
                    w_z_nxt = bus.alu_zero;
                end
                w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc  <= PC_WIDTH'(RESET_PC);
            r_ir  <= '0;
            r_c   <= 1'b0;
            r_z   <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_ir  <= w_ir_nxt;
            r_c   <= w_c_nxt;
            r_z   <= w_z_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.pc          = r_pc;
    assign bus.phase       = r_phase;
    assign bus.instr       = r_ir[IR_W-1:NIB_W];
    assign bus.imm         = r_ir[NIB_W-1:0];
    assign bus.addr        = w_addr;
    assign bus.C           = r_c;
    assign bus.Zeta        = r_z;
    assign bus.instr_count = r_cnt;

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed bench for nibbler_sequencer: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
// A second instance with a 4-bit counter shadows the main one to reach
// the counter wrap within a short run.
module tb_nibbler_sequencer;

    localparam logic [12:0] C_INC = 13'h1000;
    localparam logic [12:0] C_LD  = 13'h0800;
    localparam logic [12:0] C_FLG = 13'h0200;

    typedef enum int {S_PC, S_PH, S_INSTR, S_IMM, S_ADDR, S_C, S_Z, S_CNT, S_CNTW} sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    logic clock;
    logic reset;
    logic [7:0] rom [0:4095];

    exp_t q[$];
    int   n_vec;
    int   n_err;

    nibbler_sequencer_if #(.PC_WIDTH(12), .CNT_WIDTH(16)) sq ();
    nibbler_sequencer_if #(.PC_WIDTH(12), .CNT_WIDTH(4))  sqw ();

    nibbler_sequencer #(.PC_WIDTH(12), .RESET_PC(0), .CNT_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sq)
    );

    nibbler_sequencer #(.PC_WIDTH(12), .RESET_PC(0), .CNT_WIDTH(4)) dut_w (
        .clock (clock),
        .reset (reset),
        .bus   (sqw)
    );

    assign sq.rom_data   = rom[sq.pc];
    assign sqw.rom_data  = rom[sqw.pc];
    assign sqw.run       = sq.run;
    assign sqw.ctrl      = sq.ctrl;
    assign sqw.alu_carry = sq.alu_carry;
    assign sqw.alu_zero  = sq.alu_zero;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] actual(sel_e s);
        case (s)
            S_PC:    return 32'(sq.pc);
            S_PH:    return 32'(sq.phase);
            S_INSTR: return 32'(sq.instr);
            S_IMM:   return 32'(sq.imm);
            S_ADDR:  return 32'(sq.addr);
            S_C:     return 32'(sq.C);
            S_Z:     return 32'(sq.Zeta);
            S_CNT:   return 32'(sq.instr_count);
            default: return 32'(sqw.instr_count);
        endcase
    endfunction

    task automatic chk(input string name, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = s;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step(input logic [12:0] c, input logic cy, input logic z);
        sq.ctrl      = c;
        sq.alu_carry = cy;
        sq.alu_zero  = z;
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: compares all pending expectations at each falling edge.
    initial begin
        exp_t        e;
        logic [31:0] a;
        n_vec = 0;
        n_err = 0;
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.sel);
                n_vec++;
                if (a !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'h4A;
        rom[12'h001] = 8'hC3;
        rom[12'h002] = 8'h45;
        rom[12'h345] = 8'hE1;
        rom[12'h346] = 8'h23;
        rom[12'h347] = 8'hE1;
        rom[12'h348] = 8'h50;
        rom[12'h150] = 8'hE2;
        rom[12'h151] = 8'h60;
        rom[12'h260] = 8'h97;
        rom[12'h261] = 8'hB0;
        rom[12'h262] = 8'hCF;
        rom[12'h263] = 8'hFF;
        rom[12'hFFF] = 8'h5C;

        reset        = 1'b0;
        sq.run       = 1'b0;
        sq.ctrl      = '0;
        sq.alu_carry = 1'b0;
        sq.alu_zero  = 1'b0;
        #1;
        chk("rst_pc", S_PC, 0);
        chk("rst_phase", S_PH, 0);
        chk("rst_instr", S_INSTR, 0);
        chk("rst_imm", S_IMM, 0);
        chk("rst_c", S_C, 0);
        chk("rst_z", S_Z, 0);
        chk("rst_cnt", S_CNT, 0);
        chk("rst_cntw", S_CNTW, 0);
        @(negedge clock);
        #1;
        reset  = 1'b1;
        sq.run = 1'b1;

        // LIT 0xA: single byte, no PC increment in execute.
        step(C_INC, 0, 0);
        chk("lit_phase1", S_PH, 1);
        chk("lit_instr", S_INSTR, 4);
        chk("lit_imm", S_IMM, 4'hA);
        chk("lit_pc_fetch", S_PC, 1);
        step(13'b0011010000010, 0, 0);
        chk("lit_pc", S_PC, 1);
        chk("lit_phase0", S_PH, 0);
        chk("lit_cnt", S_CNT, 1);

        // JMP 0x345.
        step(C_INC, 0, 0);
        chk("jmp_pc_fetch", S_PC, 2);
        chk("jmp_instr", S_INSTR, 4'hC);
        chk("jmp_addr", S_ADDR, 12'h345);
        step(13'b0100000001000, 0, 0);
        chk("jmp_pc", S_PC, 12'h345);
        chk("jmp_cnt", S_CNT, 2);

        // JC untaken: incPC only.
        step(C_INC, 0, 0);
        chk("jc0_pc_fetch", S_PC, 12'h346);
        step(C_INC, 0, 0);
        chk("jc0_pc", S_PC, 12'h347);

        // JC taken: loadPC.
        step(C_INC, 0, 0);
        chk("jc1_addr", S_ADDR, 12'h150);
        step(C_LD, 0, 0);
        chk("jc1_pc", S_PC, 12'h150);

        // incPC and loadPC together: load wins.
        step(C_INC, 0, 0);
        chk("both_pc_fetch", S_PC, 12'h151);
        step(C_INC | C_LD, 0, 0);
        chk("both_pc", S_PC, 12'h260);
        chk("both_cnt", S_CNT, 5);

        // ADDI: flags captured.
        step(C_INC, 0, 0);
        step(C_FLG, 1, 1);
        chk("addi_c", S_C, 1);
        chk("addi_z", S_Z, 1);
        chk("addi_pc", S_PC, 12'h261);

        // OUT: flags hold, even with loadFlags during fetch.
        step(C_INC | C_FLG, 0, 0);
        chk("out_fetch_c", S_C, 1);
        chk("out_fetch_z", S_Z, 1);
        step(13'h0001, 0, 0);
        chk("out_c", S_C, 1);
        chk("out_z", S_Z, 1);
        chk("out_cnt", S_CNT, 7);

        // JMP 0xFFF, then fetch there wraps PC to 0.
        step(C_INC, 0, 0);
        chk("jfff_addr", S_ADDR, 12'hFFF);
        step(C_LD, 0, 0);
        chk("jfff_pc", S_PC, 12'hFFF);
        step(C_INC, 0, 0);
        chk("wrap_pc", S_PC, 12'h000);
        chk("wrap_instr", S_INSTR, 5);
        chk("wrap_imm", S_IMM, 4'hC);
        step(13'h0000, 0, 0);
        chk("wrap_pc_exec", S_PC, 0);
        chk("wrap_cnt", S_CNT, 9);

        // Fetch without incPC: PC holds.
        step(13'h0000, 0, 0);
        chk("noinc_pc", S_PC, 0);
        chk("noinc_instr", S_INSTR, 4);
        step(13'h0000, 0, 0);
        chk("noinc_cnt", S_CNT, 10);

        // Retire more instructions to wrap the 4-bit shadow counter.
        for (int i = 0; i < 5; i++) begin
            step(13'h0000, 0, 0);
            step(13'h0000, 0, 0);
        end
        chk("cnt15", S_CNT, 15);
        chk("cntw15", S_CNTW, 4'hF);
        step(13'h0000, 0, 0);
        step(13'h0000, 0, 0);
        chk("cnt16", S_CNT, 16);
        chk("cntw_wrap", S_CNTW, 0);

        // Freeze mid-instruction.
        step(C_INC, 0, 0);
        sq.run = 1'b0;
        for (int i = 0; i < 5; i++) step(C_INC | C_LD | C_FLG, 0, 0);
        chk("frz_pc", S_PC, 1);
        chk("frz_phase", S_PH, 1);
        chk("frz_instr", S_INSTR, 4);
        chk("frz_imm", S_IMM, 4'hA);
        chk("frz_c", S_C, 1);
        chk("frz_z", S_Z, 1);
        chk("frz_cnt", S_CNT, 16);
        chk("frz_addr", S_ADDR, 12'hAC3);
        @(negedge clock);
        #1;
        rom[12'h001] = 8'h77;
        #1;
        chk("frz_addr_track", S_ADDR, 12'hA77);
        @(negedge clock);
        #1;
        rom[12'h001] = 8'hC3;

        // Reset during execute clears state immediately.
        reset = 1'b0;
        #1;
        chk("mrst_pc", S_PC, 0);
        chk("mrst_phase", S_PH, 0);
        chk("mrst_instr", S_INSTR, 0);
        chk("mrst_imm", S_IMM, 0);
        chk("mrst_c", S_C, 0);
        chk("mrst_z", S_Z, 0);
        chk("mrst_cnt", S_CNT, 0);
        chk("mrst_addr", S_ADDR, 12'h04A);
        @(negedge clock);
        #1;
        reset  = 1'b1;
        sq.run = 1'b1;
        step(C_INC, 0, 0);
        chk("post_phase", S_PH, 1);
        chk("post_instr", S_INSTR, 4);
        chk("post_imm", S_IMM, 4'hA);
        chk("post_pc", S_PC, 1);

        repeat (2) @(negedge clock);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
